// File: rtl/swd_seq.sv
// swd_seq: sequencer between a 32-bit request/response handshake and the 8-bit swd_ise unit.
// Issues seven ISE operations per request: two byte-pair loads (op0, op1), shift plus first
// unload (op2), three unloads (op3..op5) and a flush unload (op6). Result bytes from op2..op5
// are packed MSB first into o_rsp_word.
//
// Optional feature: define SWD_SEQ_TIMEOUT_EN to bound each POLL phase to TIMEOUT cycles;
// on expiry o_err is set (sticky until i_rst) and the partial word is returned.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid/o_req_ready      request handshake; i_req_word, i_req_shamt payload
//   o_rsp_valid/i_rsp_ready      response handshake; o_rsp_word result
//   o_err                        sticky timeout flag (0 without SWD_SEQ_TIMEOUT_EN)
//   o_ise_start, o_ise_a, o_ise_b, o_ise_sr   ISE command outputs
//   i_ise_result, i_ise_wait     ISE result byte and busy
module swd_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_word,
  input  logic [7:0]  i_req_shamt,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_word,
  output logic        o_err,
  output logic        o_ise_start,
  output logic [7:0]  o_ise_a,
  output logic [7:0]  o_ise_b,
  output logic [7:0]  o_ise_sr,
  input  logic [7:0]  i_ise_result,
  input  logic        i_ise_wait
);

  typedef enum logic [2:0] {StIdle, StIssue, StGuard, StPoll, StResp} state_e;

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_op, w_op_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [7:0]  r_shamt, w_shamt_nxt;
  logic [31:0] r_rsp_word, w_rsp_word_nxt;
  logic [7:0]  r_ise_a, r_ise_b;
  logic [7:0]  w_ise_a, w_ise_b;
  logic        w_ise_start;

`ifdef SWD_SEQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] r_poll_cnt, w_poll_cnt_nxt;
  logic       r_err, w_err_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_word_nxt     = r_word;
    w_shamt_nxt    = r_shamt;
    w_rsp_word_nxt = r_rsp_word;
    // Operands hold their last ISSUE value outside ISSUE.
    w_ise_a        = r_ise_a;
    w_ise_b        = r_ise_b;
    w_ise_start    = 1'b0;
`ifdef SWD_SEQ_TIMEOUT_EN
    w_poll_cnt_nxt = r_poll_cnt;
    w_err_nxt      = r_err;
`endif
    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_word_nxt     = i_req_word;
          w_shamt_nxt    = i_req_shamt;
          w_rsp_word_nxt = 32'h0;
          w_op_nxt       = 3'd0;
          w_state_nxt    = StIssue;
        end
      end
      StIssue: begin
        w_ise_start = 1'b1;
        case (r_op)
          3'd0: begin
            w_ise_a = r_word[7:0];
            w_ise_b = r_word[15:8];
          end
          3'd1: begin
            w_ise_a = r_word[23:16];
            w_ise_b = r_word[31:24];
          end
          3'd2: begin
            w_ise_a = r_shamt;
            w_ise_b = 8'h00;
          end
          default: begin
            w_ise_a = 8'h00;
            w_ise_b = 8'h00;
          end
        endcase
        w_state_nxt = StGuard;
      end
      StGuard: begin
        // The ISE may not have raised wait yet; skip one cycle before polling it.
`ifdef SWD_SEQ_TIMEOUT_EN
        w_poll_cnt_nxt = 8'd0;
`endif
        w_state_nxt = StPoll;
      end
      StPoll: begin
        if (!i_ise_wait) begin
          case (r_op)
            3'd2:    w_rsp_word_nxt[31:24] = i_ise_result;
            3'd3:    w_rsp_word_nxt[23:16] = i_ise_result;
            3'd4:    w_rsp_word_nxt[15:8]  = i_ise_result;
            3'd5:    w_rsp_word_nxt[7:0]   = i_ise_result;
            default: ;
          endcase
          // op6 drains the unload pointer; its byte is dropped.
          if (r_op == 3'd6) begin
            w_state_nxt = StResp;
          end else begin
            w_op_nxt    = r_op + 3'd1;
            w_state_nxt = StIssue;
          end
        end
`ifdef SWD_SEQ_TIMEOUT_EN
        else if (r_poll_cnt == TimeoutLast) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StResp;
        end else begin
          w_poll_cnt_nxt = r_poll_cnt + 8'd1;
        end
`endif
      end
      StResp: begin
        if (i_rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_op       <= 3'd0;
      r_word     <= 32'h0;
      r_shamt    <= 8'h00;
      r_rsp_word <= 32'h0;
      r_ise_a    <= 8'h00;
      r_ise_b    <= 8'h00;
`ifdef SWD_SEQ_TIMEOUT_EN
      r_poll_cnt <= 8'd0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_word     <= w_word_nxt;
      r_shamt    <= w_shamt_nxt;
      r_rsp_word <= w_rsp_word_nxt;
      r_ise_a    <= w_ise_a;
      r_ise_b    <= w_ise_b;
`ifdef SWD_SEQ_TIMEOUT_EN
      r_poll_cnt <= w_poll_cnt_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  assign o_req_ready = (r_state == StIdle);
  assign o_rsp_valid = (r_state == StResp);
  assign o_rsp_word  = r_rsp_word;
  assign o_ise_start = w_ise_start;
  assign o_ise_a     = w_ise_a;
  assign o_ise_b     = w_ise_b;
  assign o_ise_sr    = 8'h00;
`ifdef SWD_SEQ_TIMEOUT_EN
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule
